// File: rtl/drive_iq_calibrator_mc.sv
// drive_iq_calibrator_mc: per-channel IQ gain/skew/DC correction on a shared 3-stage pipeline.
// Define DRIVE_CALI_SAT_EN to clamp and flag sat_event; otherwise results wrap and sat_event stays 0.
module drive_iq_calibrator_mc #(
  parameter int NUM_CH     = 4,
  parameter int IN_WIDTH   = 12,
  parameter int COEF_WIDTH = 12,
  parameter int OUT_WIDTH  = 12,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [IN_WIDTH-1:0]   i_in,
  input  logic signed [IN_WIDTH-1:0]   q_in,
  input  logic [CH_W-1:0]              ch_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic signed [OUT_WIDTH-1:0]  i_out,
  output logic signed [OUT_WIDTH-1:0]  q_out,
  output logic [CH_W-1:0]              ch_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic                         sat_event,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [2:0]                   cfg_sel,
  input  logic signed [COEF_WIDTH-1:0] cfg_data,
  input  logic                         cfg_commit
);
  localparam int FRAC = COEF_WIDTH - 2;
  localparam int PW   = IN_WIDTH + COEF_WIDTH;
  localparam int SW   = PW + 1;
  localparam int DW   = OUT_WIDTH + 1;
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic signed [COEF_WIDTH-1:0] ONE = {2'b01, {FRAC{1'b0}}};
  localparam logic signed [SW-1:0] MAX_S = {{(SW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {{(SW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
`ifdef DRIVE_CALI_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [COEF_WIDTH-1:0] alpha_i;
    logic [COEF_WIDTH-1:0] beta_i;
    logic [COEF_WIDTH-1:0] alpha_q;
    logic [COEF_WIDTH-1:0] beta_q;
    logic [OUT_WIDTH-1:0]  dc_i;
    logic [OUT_WIDTH-1:0]  dc_q;
  } coef_t;

  localparam coef_t IDENT = '{alpha_i: ONE, beta_i: '0, alpha_q: ONE, beta_q: '0, dc_i: '0, dc_q: '0};

  // Returns {clamped, value}; out-of-range values clamp when saturation is built in, else keep LSBs.
  function automatic logic [OUT_WIDTH:0] limit(input logic signed [SW-1:0] v);
    logic ovf;
    ovf = (v > MAX_S) || (v < MIN_S);
    if (SAT_EN && ovf) return {1'b1, v[SW-1] ? MIN_S[OUT_WIDTH-1:0] : MAX_S[OUT_WIDTH-1:0]};
    return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] to_dc(input logic signed [COEF_WIDTH-1:0] d);
    logic signed [OUT_WIDTH+COEF_WIDTH-1:0] ext;
    ext = d;
    return ext[OUT_WIDTH-1:0];
  endfunction

  coef_t shadow [NUM_CH];
  coef_t shadow_nxt [NUM_CH];
  coef_t active [NUM_CH];
  coef_t sel;
  logic  cfg_hit;
  logic  en;

  // Handshake: a beat moves on every cycle en is high; en = !valid_out || ready_out,
  // ready_in mirrors en, and a sample is taken when valid_in && ready_in. When en is low
  // every stage holds, so nothing is dropped or duplicated and order is preserved.
  assign en       = !valid_out || ready_out;
  assign ready_in = en;

  assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < NUM_CH_V) && (cfg_sel <= 3'd5);

  // Commit copies the post-write shadow so a same-cycle write is included.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_nxt[c] = shadow[c];
      if (cfg_hit && (int'(cfg_ch) == c)) begin
        case (cfg_sel)
          3'd0:    shadow_nxt[c].alpha_i = cfg_data;
          3'd1:    shadow_nxt[c].beta_i  = cfg_data;
          3'd2:    shadow_nxt[c].alpha_q = cfg_data;
          3'd3:    shadow_nxt[c].beta_q  = cfg_data;
          3'd4:    shadow_nxt[c].dc_i    = to_dc(cfg_data);
          3'd5:    shadow_nxt[c].dc_q    = to_dc(cfg_data);
          default: shadow_nxt[c] = shadow[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= IDENT;
        active[c] <= IDENT;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= shadow_nxt[c];
        if (cfg_commit) active[c] <= shadow_nxt[c];
      end
    end
  end

  always_comb begin
    sel = active[0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (int'(ch_in) == c) sel = active[c];
    end
  end

  logic signed [PW-1:0] m_ai, m_bq, m_aq, m_bi;
  assign m_ai = PW'(i_in) * PW'($signed(sel.alpha_i));
  assign m_bq = PW'(q_in) * PW'($signed(sel.beta_q));
  assign m_aq = PW'(q_in) * PW'($signed(sel.alpha_q));
  assign m_bi = PW'(i_in) * PW'($signed(sel.beta_i));

  logic                        s1_valid;
  logic [CH_W-1:0]             s1_ch;
  logic signed [PW-1:0]        s1_ai, s1_bq, s1_aq, s1_bi;
  logic signed [OUT_WIDTH-1:0] s1_dci, s1_dcq;

  logic                        s2_valid;
  logic [CH_W-1:0]             s2_ch;
  logic signed [OUT_WIDTH-1:0] s2_i, s2_q, s2_dci, s2_dcq;
  logic                        s2_sat;

  logic signed [SW-1:0] sum_i, sum_q;
  logic [OUT_WIDTH:0]   lim2_i, lim2_q, lim3_i, lim3_q;
  logic signed [DW-1:0] d_i, d_q;

  assign sum_i  = SW'(s1_ai) + SW'(s1_bq);
  assign sum_q  = SW'(s1_aq) + SW'(s1_bi);
  assign lim2_i = limit(sum_i >>> FRAC);
  assign lim2_q = limit(sum_q >>> FRAC);
  assign d_i    = DW'(s2_i) + DW'(s2_dci);
  assign d_q    = DW'(s2_q) + DW'(s2_dcq);
  assign lim3_i = limit(SW'(d_i));
  assign lim3_q = limit(SW'(d_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_ai     <= '0;
      s1_bq     <= '0;
      s1_aq     <= '0;
      s1_bi     <= '0;
      s1_dci    <= '0;
      s1_dcq    <= '0;
      s2_valid  <= 1'b0;
      s2_ch     <= '0;
      s2_i      <= '0;
      s2_q      <= '0;
      s2_dci    <= '0;
      s2_dcq    <= '0;
      s2_sat    <= 1'b0;
      valid_out <= 1'b0;
      ch_out    <= '0;
      i_out     <= '0;
      q_out     <= '0;
      sat_event <= 1'b0;
    end else if (en) begin
      s1_valid  <= valid_in;
      s1_ch     <= ch_in;
      s1_ai     <= m_ai;
      s1_bq     <= m_bq;
      s1_aq     <= m_aq;
      s1_bi     <= m_bi;
      s1_dci    <= sel.dc_i;
      s1_dcq    <= sel.dc_q;
      s2_valid  <= s1_valid;
      s2_ch     <= s1_ch;
      s2_i      <= lim2_i[OUT_WIDTH-1:0];
      s2_q      <= lim2_q[OUT_WIDTH-1:0];
      s2_dci    <= s1_dci;
      s2_dcq    <= s1_dcq;
      s2_sat    <= lim2_i[OUT_WIDTH] | lim2_q[OUT_WIDTH];
      valid_out <= s2_valid;
      ch_out    <= s2_ch;
      i_out     <= lim3_i[OUT_WIDTH-1:0];
      q_out     <= lim3_q[OUT_WIDTH-1:0];
      sat_event <= s2_sat | lim3_i[OUT_WIDTH] | lim3_q[OUT_WIDTH];
    end
  end
endmodule

// File: tb/tb_drive_iq_calibrator_mc.sv
// tb_drive_iq_calibrator_mc: scoreboard bench; a cycle-level coefficient model predicts each output beat.
// Expectations follow the DRIVE_CALI_SAT_EN build option in the same way as the design.
module tb_drive_iq_calibrator_mc;
  localparam int NUM_CH = 4;
  localparam int IW     = 12;
  localparam int CW     = 12;
  localparam int OW     = 12;
  localparam int CH_W   = 2;
  localparam int FRAC   = CW - 2;
  localparam int EW     = CH_W + 1 + 2 * OW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [IW-1:0] i_in, q_in;
  logic [CH_W-1:0]      ch_in;
  logic                 valid_in, ready_in;
  logic signed [OW-1:0] i_out, q_out;
  logic [CH_W-1:0]      ch_out;
  logic                 valid_out, ready_out, sat_event;
  logic                 cfg_we, cfg_commit;
  logic [CH_W-1:0]      cfg_ch;
  logic [2:0]           cfg_sel;
  logic signed [CW-1:0] cfg_data;

  drive_iq_calibrator_mc dut (
    .clk(clk), .rst_n(rst_n),
    .i_in(i_in), .q_in(q_in), .ch_in(ch_in), .valid_in(valid_in), .ready_in(ready_in),
    .i_out(i_out), .q_out(q_out), .ch_out(ch_out), .valid_out(valid_out), .ready_out(ready_out),
    .sat_event(sat_event),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int m_sh [NUM_CH][6];
  int m_act[NUM_CH][6];

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint trunc_ow(input longint v);
    longint w;
    w = v & ((64'sd1 <<< OW) - 1);
    if (w >= (64'sd1 <<< (OW - 1))) w = w - (64'sd1 <<< OW);
    return w;
  endfunction

  function automatic longint lim(input longint v, inout bit sat);
    longint mx, mn;
    mx = (64'sd1 <<< (OW - 1)) - 1;
    mn = -(64'sd1 <<< (OW - 1));
`ifdef DRIVE_CALI_SAT_EN
    if (v > mx) begin sat = 1'b1; return mx; end
    if (v < mn) begin sat = 1'b1; return mn; end
    return v;
`else
    return trunc_ow(v);
`endif
  endfunction

  function automatic logic [EW-1:0] model(input int ch, input int i, input int q);
    longint si, sq, di, dq;
    bit sat;
    sat = 1'b0;
    si = lim((longint'(i) * m_act[ch][0] + longint'(q) * m_act[ch][3]) >>> FRAC, sat);
    sq = lim((longint'(q) * m_act[ch][2] + longint'(i) * m_act[ch][1]) >>> FRAC, sat);
    di = lim(si + trunc_ow(m_act[ch][4]), sat);
    dq = lim(sq + trunc_ow(m_act[ch][5]), sat);
    return {CH_W'(ch), sat, OW'(di), OW'(dq)};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < 6; s++) begin
        m_sh[c][s]  = (s == 0 || s == 2) ? (1 << FRAC) : 0;
        m_act[c][s] = m_sh[c][s];
      end
    end
  endtask

  // Driver tasks are entered and left 1ns after a rising edge.
  task automatic send(input int ch, input int i, input int q);
    int wc;
    ch_in = CH_W'(ch); i_in = IW'(i); q_in = IW'(q); valid_in = 1'b1;
    wc = 0;
    @(negedge clk);
    while (!ready_in && wc < 50) begin @(negedge clk); wc++; end
    if (!ready_in) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = 3'(sel); cfg_data = CW'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [EW-1:0] e;
    int lat;
    rst_n = 1'b0; valid_in = 1'b0; i_in = '0; q_in = '0; ch_in = '0; ready_out = 1'b1;
    cfg_we = 1'b0; cfg_commit = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (valid_out && ready_out) begin
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else begin
              e = exp_q.pop_front();
              check("ch_out", ch_out, e[EW-1 -: CH_W]);
              check("sat_event", sat_event, e[2*OW]);
              check("i_out", i_out, $signed(e[2*OW-1 -: OW]));
              check("q_out", q_out, $signed(e[OW-1:0]));
            end
          end
          if (valid_in && ready_in) exp_q.push_back(model(int'(ch_in), int'(i_in), int'(q_in)));
          if (cfg_we && int'(cfg_ch) < NUM_CH && cfg_sel <= 3'd5) m_sh[cfg_ch][cfg_sel] = int'(cfg_data);
          if (cfg_commit) m_act = m_sh;
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_ch_out", ch_out, 0);
    check("rst_sat_event", sat_event, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready_in", ready_in, 1);

    // Identity after reset, and three-cycle latency.
    send(0, 100, -50);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (valid_out) break;
    end
    check("latency", lat, 3);
    drain();

    // Channel 2 gain, skew and DC; other channels stay identity.
    cfg_write(2, 0, 512); cfg_write(2, 3, 256); cfg_write(2, 4, 10);
    commit();
    send(2, 400, 200); send(0, 400, 200); send(1, 400, 200); send(3, 400, 200);
    drain();

    // Uncommitted write is invisible; commit cycle sample keeps old set.
    cfg_write(1, 0, 0);
    send(1, 300, 0);
    cfg_commit = 1'b1;
    send(1, 300, 0);
    cfg_commit = 1'b0;
    send(1, 300, 0);
    drain();

    // Write and commit in the same cycle; out-of-range selects ignored.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 3'd5; cfg_data = -12'sd7;
    commit();
    cfg_we = 1'b0;
    cfg_write(0, 6, 99); cfg_write(0, 7, 55);
    commit();
    send(0, -1000, 2000);
    drain();

    // Large gain overflow.
    cfg_write(3, 0, 2047);
    commit();
    send(3, 2047, 0);
    send(3, -2048, -2048);
    drain();

    // Mid-stream stall of five cycles.
    fork
      begin
        for (int k = 0; k < 10; k++)
          send($urandom_range(0, 3), int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
      end
      begin
        repeat (4) @(posedge clk);
        #2 ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_ready_in", ready_in, 0);
        end
        @(posedge clk);
        #2 ready_out = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure, including DC-stage overflow on ch1.
    cfg_write(1, 2, -2048); cfg_write(1, 1, 1536); cfg_write(1, 5, -700); cfg_write(1, 4, 900);
    commit();
    fork
      begin
        for (int k = 0; k < 30; k++)
          send($urandom_range(0, 3), int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #2 ready_out = ($urandom_range(0, 3) != 0);
        end
        ready_out = 1'b1;
      end
    join
    drain();

    // Asynchronous reset in mid-stream returns everything to identity.
    send(2, 400, 200); send(2, 100, 100); send(1, 50, 60);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid_out", valid_out, 0);
    check("async_rst_i_out", i_out, 0);
    exp_q.delete();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2, 100, -50);
    send(1, 100, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
